// File: rtl/trace_pkg.sv
// Purpose: shared types and helpers for the trace source arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: arb_state_t FSM encoding, vector_t lane bundle, CREDIT_W width helper.
package trace_pkg;

  localparam int TRACE_N          = 8;
  localparam int TRACE_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2
  } arb_state_t;

  typedef logic [TRACE_N-1:0][TRACE_DATA_WIDTH-1:0] vector_t;

  // Width of a counter that must hold 0..depth-1 free slots plus headroom.
  function automatic int CREDIT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Purpose: rotating-priority search over NUM_SRC requests, starting after 'last'.
// Latency: combinational.
// Backpressure: none; pure function of req and last.
// Ports: req (request vector), last (previous winner), found (any request), idx (winner).
module rr_picker #(
  parameter int NUM_SRC = 4,
  localparam int IDX_W  = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] w_cand;

  // Visit last+1, last+2, ... wrapping; 'last' itself is visited last so a
  // lone requester can be re-granted.
  always_comb begin
    found  = 1'b0;
    idx    = last;
    w_cand = last;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_cand = IDX_W'((int'(last) + k) % NUM_SRC);
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/trace_source_arbiter.sv
// Purpose: frame-atomic round-robin arbiter sharing one input buffer among NUM_SRC trace sources.
// Latency: 1 arbitration cycle per frame; accept -> enqueue/eof_out/vector_out 1 cycle.
// Backpressure: src_ready (combinational) drops when credits hit 0; grant is kept, other sources wait.
// Ports: clk/rst_n (async active-low); tracing gates new grants; src_valid/src_eof/src_vector
//   per source in, src_ready out; ib_dequeue returns a credit; enqueue/eof_out/vector_out
//   registered buffer write; grant_id current/last winner; credits free slots (debug).
// Build option: TRACE_ARB_BURST_LIMIT_EN caps a grant at MAX_BURST beats, closing it with eof_out=1.
module trace_source_arbiter
  import trace_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int IB_DEPTH   = 4,
  parameter int MAX_BURST  = 16,
  localparam int GID_W     = $clog2(NUM_SRC),
  localparam int CW        = CREDIT_W(IB_DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   tracing,
  input  logic [NUM_SRC-1:0]                     src_valid,
  input  logic [NUM_SRC-1:0]                     src_eof,
  input  logic [NUM_SRC-1:0][N-1:0][DATA_WIDTH-1:0] src_vector,
  output logic [NUM_SRC-1:0]                     src_ready,
  input  logic                                   ib_dequeue,
  output logic                                   enqueue,
  output logic                                   eof_out,
  output logic [N-1:0][DATA_WIDTH-1:0]           vector_out,
  output logic [GID_W-1:0]                       grant_id,
  output logic [CW-1:0]                          credits
);

  // One slot of the buffer is never usable, so the pool starts at depth-1.
  localparam logic [CW-1:0]    CRED_MAX = CW'(IB_DEPTH - 1);
  // Resetting to the highest index makes source 0 the first one searched.
  localparam logic [GID_W-1:0] GID_RST  = GID_W'(NUM_SRC - 1);

  arb_state_t                   r_state;
  arb_state_t                   w_next_state;
  logic [GID_W-1:0]             r_grant;
  logic [GID_W-1:0]             w_idx;
  logic [CW-1:0]                r_credits;
  logic                         r_enq;
  logic                         r_eof;
  logic [N-1:0][DATA_WIDTH-1:0] r_vec;
  logic                         w_found;
  logic                         w_has_credit;
  logic                         w_accept;
  logic                         w_force;
  logic                         w_close;
  logic                         w_load_grant;
  logic [NUM_SRC-1:0]           w_ready;

  rr_picker #(
    .NUM_SRC (NUM_SRC)
  ) u_picker (
    .req   (src_valid),
    .last  (r_grant),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_has_credit = (r_credits != '0);
  assign w_accept     = (r_state == BURST) && src_valid[r_grant] && w_has_credit;
  // A frame closes on a real eof or on a forced burst-limit cut.
  assign w_close      = src_eof[r_grant] | w_force;

`ifdef TRACE_ARB_BURST_LIMIT_EN
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  logic [BEAT_W-1:0] r_beats;

  assign w_force = w_accept && (r_beats == BEAT_W'(MAX_BURST - 1));

  // Counts accepts inside the current grant; cleared whenever not in BURST so
  // every new grant starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beats <= '0;
    end else if (r_state != BURST) begin
      r_beats <= '0;
    end else if (w_accept) begin
      r_beats <= r_beats + BEAT_W'(1);
    end
  end
`else
  logic w_unused_max_burst;

  assign w_force            = 1'b0;
  assign w_unused_max_burst = (MAX_BURST > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load_grant = 1'b0;
    w_ready      = '0;
    case (r_state)
      IDLE: begin
        if (tracing) begin
          w_next_state = ARB;
        end
      end
      ARB: begin
        if (!tracing) begin
          w_next_state = IDLE;
        end else if (w_found) begin
          w_load_grant = 1'b1;
          w_next_state = BURST;
        end
      end
      BURST: begin
        // tracing is only consulted once the frame closes, so a frame in
        // flight always completes.
        w_ready[r_grant] = w_has_credit;
        if (w_accept && w_close) begin
          w_next_state = tracing ? ARB : IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= GID_RST;
    end else if (w_load_grant) begin
      r_grant <= w_idx;
    end
  end

  // Simultaneous accept and dequeue cancel; a dequeue at the ceiling is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= CRED_MAX;
    end else if (w_accept && !ib_dequeue) begin
      r_credits <= r_credits - CW'(1);
    end else if (!w_accept && ib_dequeue && (r_credits != CRED_MAX)) begin
      r_credits <= r_credits + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enq <= 1'b0;
      r_eof <= 1'b0;
      r_vec <= '0;
    end else begin
      r_enq <= w_accept;
      r_eof <= w_accept && w_close;
      if (w_accept) begin
        r_vec <= src_vector[r_grant];
      end
    end
  end

  assign src_ready  = w_ready;
  assign enqueue    = r_enq;
  assign eof_out    = r_eof;
  assign vector_out = r_vec;
  assign grant_id   = r_grant;
  assign credits    = r_credits;

endmodule

// File: tb/tb_trace_source_arbiter.sv
// Purpose: self-checking bench for trace_source_arbiter against a frame-level round-robin model.
// Latency: n/a.
// Backpressure: sources hold their head beat until accepted; buffer pops modelled by occupancy count.
module tb_trace_source_arbiter;

  localparam int N    = 8;
  localparam int DW   = 32;
  localparam int NS   = 4;
  localparam int IBD  = 4;
  localparam int MAXB = 4;
  localparam int GW   = 2;
  localparam int CW   = 3;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t vec;
    logic eof;
    int   cyc;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 tracing = 1'b0;
  logic [NS-1:0]        src_valid = '0;
  logic [NS-1:0]        src_eof = '0;
  logic [NS-1:0][N-1:0][DW-1:0] src_vector = '0;
  logic [NS-1:0]        src_ready;
  logic                 ib_dequeue = 1'b0;
  logic                 enqueue;
  logic                 eof_out;
  vec_t                 vector_out;
  logic [GW-1:0]        grant_id;
  logic [CW-1:0]        credits;

  always #5 clk = ~clk;

  trace_source_arbiter #(
    .N          (N),
    .DATA_WIDTH (DW),
    .NUM_SRC    (NS),
    .IB_DEPTH   (IBD),
    .MAX_BURST  (MAXB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tracing    (tracing),
    .src_valid  (src_valid),
    .src_eof    (src_eof),
    .src_vector (src_vector),
    .src_ready  (src_ready),
    .ib_dequeue (ib_dequeue),
    .enqueue    (enqueue),
    .eof_out    (eof_out),
    .vector_out (vector_out),
    .grant_id   (grant_id),
    .credits    (credits)
  );

  int checks = 0;
  int errors = 0;

  beat_t         src_q[NS][$];
  beat_t         exp_q[$];
  beat_t         out_q[$];
  logic [NS-1:0] acc;
  int            occ;
  int            cyc;
  int            dq_mode;
  logic          dq_manual;
  int            cr_bad;
  int            ovf_bad;
  int            oh_bad;
  int            fr_cnt;

  // One clock of bench activity: pop accepted beats, present heads, drive
  // dequeue, then sample outputs and update the buffer occupancy model.
  task automatic step();
    @(posedge clk);
    if (ib_dequeue && occ > 0) occ--;
    #1;
    for (int i = 0; i < NS; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
    end
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        src_valid[i]  = 1'b1;
        src_vector[i] = src_q[i][0].vec;
        src_eof[i]    = src_q[i][0].eof;
      end else begin
        src_valid[i]  = 1'b0;
        src_vector[i] = '0;
        src_eof[i]    = 1'b0;
      end
    end
    case (dq_mode)
      0:       ib_dequeue = 1'b0;
      1:       ib_dequeue = (occ > 0) && ($urandom_range(0, 1) == 1);
      2:       ib_dequeue = (occ > 0);
      default: ib_dequeue = dq_manual;
    endcase
    @(negedge clk);
    cyc++;
    acc = src_valid & src_ready;
    if ($countones(src_ready) > 1) oh_bad++;
    if (enqueue) begin
      if (occ >= IBD - 1) ovf_bad++;
      out_q.push_back('{vector_out, eof_out, cyc});
      occ++;
    end
    if (credits !== CW'(IBD - 1 - occ)) cr_bad++;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    tracing    = 1'b0;
    src_valid  = '0;
    src_eof    = '0;
    src_vector = '0;
    ib_dequeue = 1'b0;
    dq_mode    = 0;
    dq_manual  = 1'b0;
    for (int i = 0; i < NS; i++) src_q[i].delete();
    out_q.delete();
    exp_q.delete();
    acc     = '0;
    occ     = 0;
    cr_bad  = 0;
    ovf_bad = 0;
    oh_bad  = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic add_frame(input int sid, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      for (int l = 1; l < N; l++) b.vec[l] = $urandom;
      b.vec[0] = {8'(sid), 8'(fr_cnt), 16'(k)};
      b.eof    = (k == len - 1);
      b.cyc    = 0;
      src_q[sid].push_back(b);
    end
    fr_cnt++;
  endtask

  // Frame-level reference: with every queued frame present from the start and
  // tracing held high, output order is round-robin over non-empty sources,
  // one whole frame (or one burst-limited slice) per grant.
  task automatic build_expected(input int start_last);
    beat_t mq[NS][$];
    int    last;
    int    pick;
    int    n;
    logic  done;
    beat_t b;
    last = start_last;
    exp_q.delete();
    for (int i = 0; i < NS; i++) mq[i] = src_q[i];
    done = 1'b0;
    while (!done) begin
      pick = -1;
      for (int k = 1; k <= NS; k++) begin
        if (pick < 0 && mq[(last + k) % NS].size() > 0) pick = (last + k) % NS;
      end
      if (pick < 0) begin
        done = 1'b1;
      end else begin
        n = 0;
        b.eof = 1'b0;
        while (!b.eof) begin
          b = mq[pick].pop_front();
          n++;
`ifdef TRACE_ARB_BURST_LIMIT_EN
          if (n == MAXB) b.eof = 1'b1;
`endif
          exp_q.push_back(b);
        end
        last = pick;
      end
    end
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (enqueue !== 1'b0) begin errors++; $display("FAIL reset_enqueue got %0b exp 0", enqueue); end
    checks++; if (eof_out !== 1'b0) begin errors++; $display("FAIL reset_eof got %0b exp 0", eof_out); end
    checks++; if (vector_out !== '0) begin errors++; $display("FAIL reset_vector got %h exp 0", vector_out[0]); end
    checks++; if (grant_id !== GW'(NS - 1)) begin errors++; $display("FAIL reset_grant got %0d exp %0d", grant_id, NS - 1); end
    checks++; if (credits !== CW'(IBD - 1)) begin errors++; $display("FAIL reset_credits got %0d exp %0d", credits, IBD - 1); end
    checks++; if (src_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 0", src_ready); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    tracing = 1'b1;
    add_frame(1, 5);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    checks++; if (credits !== CW'(IBD - 1)) begin errors++; $display("FAIL midrst_credits got %0d exp %0d", credits, IBD - 1); end
    checks++; if (enqueue !== 1'b0) begin errors++; $display("FAIL midrst_enqueue got %0b exp 0", enqueue); end
    checks++; if (grant_id !== GW'(NS - 1)) begin errors++; $display("FAIL midrst_grant got %0d exp %0d", grant_id, NS - 1); end
    checks++; if (src_ready !== '0) begin errors++; $display("FAIL midrst_ready got %b exp 0", src_ready); end
    checks++; if (vector_out !== '0) begin errors++; $display("FAIL midrst_vector got %h exp 0", vector_out[0]); end
  endtask

  task automatic test_single_frame();
    do_reset();
    tracing = 1'b1;
    add_frame(0, 3);
    build_expected(NS - 1);
    repeat (2) step();
    checks++; if (grant_id !== GW'(0)) begin errors++; $display("FAIL single_grant got %0d exp 0", grant_id); end
    run_until(3, 20);
    repeat (3) step();
    checks++; if (out_q.size() != 3) begin errors++; $display("FAIL single_count got %0d exp 3", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (out_q[i].vec !== exp_q[i].vec || out_q[i].eof !== exp_q[i].eof) begin
        errors++;
        $display("FAIL single_beat%0d got %h/%0b exp %h/%0b", i, out_q[i].vec[0], out_q[i].eof, exp_q[i].vec[0], exp_q[i].eof);
      end
    end
    checks++; if (credits !== CW'(0)) begin errors++; $display("FAIL single_credits got %0d exp 0", credits); end
    checks++; if (src_ready !== '0) begin errors++; $display("FAIL single_ready got %b exp 0", src_ready); end
    checks++; if (cr_bad != 0) begin errors++; $display("FAIL single_credit_track got %0d bad cycles exp 0", cr_bad); end
  endtask

  task automatic test_round_robin();
    do_reset();
    dq_mode = 2;
    tracing = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NS; s++) add_frame(s, 1);
    end
    build_expected(NS - 1);
    run_until(8, 100);
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL rr_count got %0d exp 8", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (out_q[i].vec !== exp_q[i].vec || out_q[i].vec[0][31:24] !== 8'(i % NS)) begin
        errors++;
        $display("FAIL rr_order%0d got %h exp %h", i, out_q[i].vec[0], exp_q[i].vec[0]);
      end
      if (i > 0) begin
        checks++;
        if (out_q[i].cyc - out_q[i-1].cyc != 2) begin
          errors++;
          $display("FAIL rr_gap%0d got %0d exp 2", i, out_q[i].cyc - out_q[i-1].cyc);
        end
      end
    end
  endtask

  task automatic test_credit_stall();
    do_reset();
    tracing = 1'b1;
    add_frame(0, 5);
    repeat (8) step();
    checks++; if (out_q.size() != 3) begin errors++; $display("FAIL stall_count got %0d exp 3", out_q.size()); end
    checks++; if (src_ready !== '0) begin errors++; $display("FAIL stall_ready got %b exp 0", src_ready); end
    checks++; if (credits !== CW'(0)) begin errors++; $display("FAIL stall_credits got %0d exp 0", credits); end
    dq_mode   = 3;
    dq_manual = 1'b1;
    step();
    dq_manual = 1'b0;
    checks++; if (src_ready !== '0) begin errors++; $display("FAIL stall_pulse_ready got %b exp 0", src_ready); end
    step();
    checks++; if (src_ready !== 4'b0001) begin errors++; $display("FAIL stall_resume_ready got %b exp 0001", src_ready); end
    step();
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL stall_resume_count got %0d exp 4", out_q.size()); end
    checks++; if (src_ready !== '0) begin errors++; $display("FAIL stall_restall_ready got %b exp 0", src_ready); end
    checks++; if (grant_id !== GW'(0)) begin errors++; $display("FAIL stall_grant got %0d exp 0", grant_id); end
    checks++; if (cr_bad != 0 || ovf_bad != 0) begin errors++; $display("FAIL stall_track got %0d/%0d exp 0/0", cr_bad, ovf_bad); end
  endtask

  task automatic test_same_cycle();
    logic seen;
    do_reset();
    dq_mode = 3;
    tracing = 1'b1;
    add_frame(0, 4);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (credits === CW'(2)) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL same_reach got credits %0d exp 2", credits); end
    checks++; if (acc !== 4'b0001) begin errors++; $display("FAIL same_accepting got %b exp 0001", acc); end
    ib_dequeue = 1'b1;
    step();
    checks++; if (credits !== CW'(2)) begin errors++; $display("FAIL same_credits got %0d exp 2", credits); end
    checks++; if (out_q.size() != 2) begin errors++; $display("FAIL same_count got %0d exp 2", out_q.size()); end
  endtask

  task automatic test_tracing_drop();
    logic seen;
    do_reset();
    dq_mode = 2;
    tracing = 1'b1;
    add_frame(0, 4);
    add_frame(1, 2);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (acc[0] && src_q[0].size() == 3) seen = 1'b1;
    end
    tracing = 1'b0;
    repeat (15) step();
    checks++; if (!seen) begin errors++; $display("FAIL drop_reach got 0 exp 1"); end
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL drop_count got %0d exp 4", out_q.size()); end
    for (int i = 0; i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].vec[0] !== {8'd0, out_q[0].vec[0][23:16], 16'(i)} || out_q[i].eof !== (i == 3)) begin
        errors++;
        $display("FAIL drop_beat%0d got %h/%0b exp src0 beat %0d", i, out_q[i].vec[0], out_q[i].eof, i);
      end
    end
    checks++; if (src_q[1].size() != 2) begin errors++; $display("FAIL drop_src1_left got %0d exp 2", src_q[1].size()); end
    checks++; if (grant_id !== GW'(0)) begin errors++; $display("FAIL drop_grant got %0d exp 0", grant_id); end
    checks++; if (src_ready !== '0) begin errors++; $display("FAIL drop_ready got %b exp 0", src_ready); end
  endtask

  task automatic test_burst_limit();
    do_reset();
    dq_mode = 2;
    tracing = 1'b1;
    add_frame(0, 6);
    add_frame(1, 2);
    build_expected(NS - 1);
    run_until(8, 100);
    repeat (3) step();
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL burst_count got %0d exp 8", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (out_q[i].vec !== exp_q[i].vec || out_q[i].eof !== exp_q[i].eof) begin
        errors++;
        $display("FAIL burst_beat%0d got %h/%0b exp %h/%0b", i, out_q[i].vec[0], out_q[i].eof, exp_q[i].vec[0], exp_q[i].eof);
      end
    end
    if (out_q.size() == 8) begin
`ifdef TRACE_ARB_BURST_LIMIT_EN
      checks++; if (out_q[3].eof !== 1'b1) begin errors++; $display("FAIL burst_cut_eof got %0b exp 1", out_q[3].eof); end
      checks++; if (out_q[4].vec[0][31:24] !== 8'd1) begin errors++; $display("FAIL burst_next_src got %0d exp 1", out_q[4].vec[0][31:24]); end
`else
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (out_q[i].cyc - out_q[i-1].cyc != 1 || out_q[i].vec[0][31:24] !== 8'd0) begin
          errors++;
          $display("FAIL burst_contig%0d got gap %0d src %0d exp gap 1 src 0", i, out_q[i].cyc - out_q[i-1].cyc, out_q[i].vec[0][31:24]);
        end
      end
`endif
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      do_reset();
      dq_mode = 1;
      tracing = 1'b1;
      for (int s = 0; s < NS; s++) begin
        int nf;
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) add_frame(s, $urandom_range(1, 6));
      end
      add_frame(2, $urandom_range(1, 6));
      build_expected(NS - 1);
      run_until(exp_q.size(), 4000);
      dq_mode = 2;
      repeat (10) step();
      checks++;
      if (out_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count got %0d exp %0d", it, out_q.size(), exp_q.size());
      end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (out_q[i].vec !== exp_q[i].vec || out_q[i].eof !== exp_q[i].eof) begin
          errors++;
          $display("FAIL rand%0d_beat%0d got %h/%0b exp %h/%0b", it, i, out_q[i].vec[0], out_q[i].eof, exp_q[i].vec[0], exp_q[i].eof);
        end
      end
      checks++; if (credits !== CW'(IBD - 1)) begin errors++; $display("FAIL rand%0d_drain_credits got %0d exp %0d", it, credits, IBD - 1); end
      checks++;
      if (cr_bad != 0 || ovf_bad != 0 || oh_bad != 0) begin
        errors++;
        $display("FAIL rand%0d_track got credit %0d overflow %0d onehot %0d exp 0/0/0", it, cr_bad, ovf_bad, oh_bad);
      end
    end
  endtask

  initial begin
    cyc    = 0;
    fr_cnt = 0;
    test_reset();
    test_reset_midframe();
    test_single_frame();
    test_round_robin();
    test_credit_stall();
    test_same_cycle();
    test_tracing_drop();
    test_burst_limit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
